addinv_pipe: RTL
================

ADDINV_PIPE -- requirements
Module: addinv_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width per lane, SHALL be >= 1.
REQ-002 Parameter LANES, default 1: independent parallel lanes, SHALL be >= 1.
REQ-003 Parameter DEPTH, default 2: pipeline stages, SHALL be >= 1.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  block accepts beat this cycle.
REQ-008 in_mode  in  2  operation for this beat, per package enum.
REQ-009 in_a  in  LANES*WIDTH  operand A; lane i at bits [i*WIDTH +: WIDTH].
REQ-010 in_b  in  LANES*WIDTH  operand B; same packing.
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  consumer accepts result this cycle.
REQ-013 out_z  out  LANES*WIDTH  result; same packing.
REQ-014 out_ovf  out  LANES  per-lane overflow flag; exists only under ADDINV_PIPE_OVF_EN.

Function
REQ-015 Per lane, mode ADD(0): z = a+b; INV(1): z = ~(a+b); ADDINV(2): z = a + ~(a+b); SUB(3): z = a-b; all results modulo 2^WIDTH, intermediate a+b truncated to WIDTH before inversion.
REQ-016 Transfer on either port SHALL occur only in a cycle where valid and ready are both 1.
REQ-017 Result SHALL be computed from operands and mode captured at input transfer; mode SHALL be independent per beat.
REQ-018 With out_ready held 1, a beat accepted at edge N SHALL appear with out_valid=1 after edge N+DEPTH-1 (DEPTH cycles of latency; throughput one beat per cycle).
REQ-019 Each stage SHALL advance when empty or when its downstream stage advances (bubbles collapse); last stage advances when out_ready=1.
REQ-020 in_ready SHALL be 1 whenever stage 0 is empty or advancing; it MAY depend combinationally on out_ready.
REQ-021 Output beats SHALL leave in acceptance order; no beat dropped or duplicated; at most DEPTH beats in flight.
REQ-022 While out_valid=1 and out_ready=0, out_z (and out_ovf) SHALL hold stable.
REQ-023 Simultaneous accept and emit in the same cycle with pipe full SHALL be supported without a lost cycle.

Reset
REQ-024 rst=1 at an edge SHALL clear all stage-valid bits; out_valid=0 from the next cycle; in-flight beats discarded.
REQ-025 During rst=1, in_ready SHALL be 0; out_z and out_ovf SHALL read 0 after reset.
REQ-026 Data registers other than output MAY be left unreset.

Configuration
REQ-027 Macro ADDINV_PIPE_OVF_EN defined: out_ovf present; ADD flags unsigned carry-out, SUB flags borrow, INV/ADDINV flag carry-out of internal a+b; flag pipelined with its beat.
REQ-028 Macro undefined: out_ovf port and all related logic absent; other behaviour identical.

Structure
REQ-029 Package addinv_pkg SHALL hold the 2-bit mode enum (ADD, INV, ADDINV, SUB) and default WIDTH/LANES/DEPTH constants.
REQ-030 Per-lane combinational arithmetic SHALL be a sub-module addinv_lane, instantiated LANES times; pipeline/handshake logic stays in addinv_pipe.

Verification
REQ-031 WIDTH=8, LANES=1, DEPTH=2, ADDINV, out_ready=1: (07,20),(8a,12),(71,b2) on consecutive cycles -> out_z df, ed, 4d, first valid 2 cycles after first accept.
REQ-032 out_ready=0 while feeding 4 beats -> in_ready drops after 2 accepted; release -> all 4 emerge in order, values intact, out_z stable while stalled.
REQ-033 LANES=4, ADD, a=04_03_02_01, b=10_20_30_40 -> out_z 14_23_32_41; SUB mode -> f4_e3_d2_c1.
REQ-034 Assert rst with 2 beats in flight -> out_valid=0 next cycle, those beats never emerge; new beat after reset produces correct result.
REQ-035 With ADDINV_PIPE_OVF_EN: ADD ff+01 -> z=00, ovf=1; SUB 00-01 -> z=ff, ovf=1; ADD 01+01 -> ovf=0; without macro, same bench sans ovf compiles and passes.
REQ-036 Alternating modes per beat (ADD, INV, SUB) with random out_ready -> every result matches scoreboard model.

Source files
------------

// File: rtl/addinv_pkg.sv
// addinv_pkg: shared mode encoding and default geometry for the addinv pipeline.
package addinv_pkg;

  // Per-beat operation selector.
  typedef enum logic [1:0] {
    ADD    = 2'd0,
    INV    = 2'd1,
    ADDINV = 2'd2,
    SUB    = 2'd3
  } mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 1;
  localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/addinv_lane.sv
// addinv_lane: single-lane combinational arithmetic (ADD / INV / ADDINV / SUB).
// Optional macro ADDINV_PIPE_OVF_EN adds a carry/borrow flag output.
module addinv_lane
  import addinv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_z
`ifdef ADDINV_PIPE_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  logic [WIDTH-1:0] w_s;  // a+b truncated to WIDTH
  logic [WIDTH-1:0] w_d;  // a-b truncated to WIDTH

`ifdef ADDINV_PIPE_OVF_EN
  logic w_c;   // carry-out of a+b
  logic w_bw;  // borrow of a-b (set when a < b)
  assign {w_c, w_s}  = {1'b0, i_a} + {1'b0, i_b};
  assign {w_bw, w_d} = {1'b0, i_a} - {1'b0, i_b};
`else
  assign w_s = i_a + i_b;
  assign w_d = i_a - i_b;
`endif

  // Select the result; inversion is applied to the already-truncated sum.
  always_comb begin
    o_z = w_s;
    case (mode_e'(i_mode))
      ADD:     o_z = w_s;
      INV:     o_z = ~w_s;
      ADDINV:  o_z = i_a + ~w_s;
      SUB:     o_z = w_d;
      default: o_z = w_s;
    endcase
  end

`ifdef ADDINV_PIPE_OVF_EN
  // SUB reports borrow; every other mode reports carry of the internal a+b.
  always_comb begin
    o_ovf = w_c;
    if (mode_e'(i_mode) == SUB) o_ovf = w_bw;
  end
`endif

endmodule

// File: rtl/addinv_pipe.sv
// addinv_pipe: LANES parallel addinv lanes feeding a DEPTH-stage valid/ready
// pipeline with bubble collapsing. Result is computed at input acceptance and
// carried through the stages. Optional macro ADDINV_PIPE_OVF_EN adds out_ovf.
module addinv_pipe
  import addinv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_z
`ifdef ADDINV_PIPE_OVF_EN
  ,
  output logic [LANES-1:0]       out_ovf
`endif
);

  logic [LANES*WIDTH-1:0]            w_z;
  logic [DEPTH-1:0]                  r_vld;
  logic [DEPTH-1:0]                  w_adv;
  logic [DEPTH-1:0][LANES*WIDTH-1:0] r_z;
  logic                              w_acc;
`ifdef ADDINV_PIPE_OVF_EN
  logic [LANES-1:0]                  w_ovf;
  logic [DEPTH-1:0][LANES-1:0]       r_ovf;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    addinv_lane #(.WIDTH(WIDTH)) u_lane (
      .i_a    (in_a[g*WIDTH +: WIDTH]),
      .i_b    (in_b[g*WIDTH +: WIDTH]),
      .i_mode (in_mode),
      .o_z    (w_z[g*WIDTH +: WIDTH])
`ifdef ADDINV_PIPE_OVF_EN
      ,
      .o_ovf  (w_ovf[g])
`endif
    );
  end

  // A stage may load when it is empty or its contents move on downstream.
  always_comb begin
    w_adv          = '0;
    w_adv[DEPTH-1] = ~r_vld[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) w_adv[i] = ~r_vld[i] | w_adv[i+1];
  end

  assign in_ready  = w_adv[0] & ~rst;
  assign w_acc     = in_valid & in_ready;
  assign out_valid = r_vld[DEPTH-1];
  assign out_z     = r_z[DEPTH-1];
`ifdef ADDINV_PIPE_OVF_EN
  assign out_ovf   = r_ovf[DEPTH-1];
`endif

  // Stage registers; data only moves with a valid beat so out_z keeps the
  // last real result (zero after reset) rather than bubble garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_z   <= '0;
`ifdef ADDINV_PIPE_OVF_EN
      r_ovf <= '0;
`endif
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= w_acc;
        if (w_acc) begin
          r_z[0]   <= w_z;
`ifdef ADDINV_PIPE_OVF_EN
          r_ovf[0] <= w_ovf;
`endif
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_z[i]   <= r_z[i-1];
`ifdef ADDINV_PIPE_OVF_EN
            r_ovf[i] <= r_ovf[i-1];
`endif
          end
        end
      end
    end
  end

endmodule
